add_sub_sequencer: RTL and testbench

ADD_SUB_SEQUENCER -- requirements
Module: add_sub_sequencer

---
 rtl/add_sub_sequencer_pkg.sv | 12 +
 rtl/add_sub_sequencer_adder.sv | 24 ++
 rtl/add_sub_sequencer.sv | 98 +++++++++
 tb/tb_add_sub_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_sequencer_pkg.sv
// Shared width default and FSM state encoding for the add/subtract sequencer.
package add_sub_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_sequencer_adder.sv
// Combinational ripple-carry adder used by the sequencer for both add and subtract.
module adder4_core #(
  parameter int WIDTH = 4
) (
  input  logic             c_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             c_out
);

  logic c;

  always_comb begin
    S = '0;
    c = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/add_sub_sequencer.sv
// Accumulates a counted run of operands, adding or subtracting each through one shared adder.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; result/flags hold the last sequence's values
// ST_ACCUM | accepting operands, one per op_valid cycle, until remaining hits 0
// ST_DONE  | single-cycle completion pulse, then back to idle
module add_sub_sequencer
  import add_sub_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       count,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_data,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [2:0]       remaining_q;
  logic             sub_q;
  logic             xfer;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             c_out_w;
  logic             ovf_step;

  // Subtraction is A + ~B + 1: invert the operand and feed sub in as carry.
  assign b_eff    = op_data ^ {WIDTH{sub_q}};
  assign xfer     = (state_q == ST_ACCUM) && op_valid;
  assign ovf_step = (result[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != result[WIDTH-1]);

  adder4_core #(.WIDTH(WIDTH)) u_adder (
    .c_in  (sub_q),
    .A     (result),
    .B     (b_eff),
    .S     (sum),
    .c_out (c_out_w)
  );

  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (count == 3'd0) ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        op_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && (remaining_q == 3'd1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= 3'd0;
      sub_q       <= 1'b0;
      result      <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start) begin
        remaining_q <= count;
        sub_q       <= sub;
        result      <= '0;
        carry_out   <= 1'b0;
        overflow    <= 1'b0;
      end else if (xfer) begin
        remaining_q <= remaining_q - 3'd1;
        result      <= sum;
        carry_out   <= c_out_w;
        overflow    <= overflow | ovf_step;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Directed bench for add_sub_sequencer: expected completions are queued, a monitor checks each done pulse.
module tb_add_sub_sequencer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       count;
  logic             sub;
  logic [WIDTH-1:0] op_data;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;

  add_sub_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .sub       (sub),
    .op_data   (op_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] r, input logic c, input logic o);
    exp_t e;
    e.r = r; e.c = c; e.o = o;
    exp_q.push_back(e);
  endtask

  // Drives one accepted start; returns #1 after the accepting edge.
  task automatic do_start(input logic [2:0] cnt, input logic s);
    start = 1'b1; count = cnt; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one operand until it is transferred; returns #1 after the transfer edge.
  task automatic send_op(input logic [WIDTH-1:0] v);
    logic rdy;
    bit   got;
    got = 0;
    op_data  = v;
    op_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      rdy = op_ready;
      @(posedge clk); #1;
      if (rdy) got = 1;
    end
    op_valid = 1'b0;
    if (!got) chk("op_transfer_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      chk("done_has_expectation", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("done_result", int'(result), int'(e.r));
        chk("done_carry_out", int'(carry_out), int'(e.c));
        chk("done_overflow", int'(overflow), int'(e.o));
        chk("done_busy", int'(busy), 1);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; count = 3'd0; sub = 1'b0;
    op_data = '0; op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_result", int'(result), 0);
    chk("rst_carry", int'(carry_out), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_op_ready", int'(op_ready), 0);

    // Add 5,6,7: 5+6=11 flags signed overflow, 11+7 wraps to 2 with carry.
    push_exp(4'b0010, 1'b1, 1'b1);
    do_start(3'd3, 1'b0);
    send_op(4'd5);
    chk("add_step1_result", int'(result), 5);
    send_op(4'd6);
    send_op(4'd7);
    chk("add_done_latency", int'(done), 1);
    @(posedge clk); #1;
    chk("add_done_one_cycle", int'(done), 0);
    chk("add_idle_busy", int'(busy), 0);
    chk("add_hold_result", int'(result), 2);

    // Subtract 3 then 5: 0-3=13 (borrow), 13-5=8 (no borrow).
    push_exp(4'b1000, 1'b1, 1'b0);
    do_start(3'd2, 1'b1);
    chk("sub_cleared_result", int'(result), 0);
    send_op(4'd3);
    chk("sub_step1_result", int'(result), 13);
    chk("sub_step1_carry", int'(carry_out), 0);
    send_op(4'd5);
    chk("sub_done_latency", int'(done), 1);
    @(posedge clk); #1;

    // Count zero goes straight to DONE with cleared outputs.
    push_exp(4'd0, 1'b0, 1'b0);
    do_start(3'd0, 1'b0);
    chk("zero_done", int'(done), 1);
    chk("zero_op_ready", int'(op_ready), 0);
    chk("zero_result", int'(result), 0);
    @(posedge clk); #1;
    chk("zero_after_ready", int'(op_ready), 0);

    // Stall five cycles between operands.
    push_exp(4'd3, 1'b0, 1'b0);
    do_start(3'd2, 1'b0);
    send_op(4'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_result", int'(result), 1);
      chk("stall_done", int'(done), 0);
      chk("stall_ready", int'(op_ready), 1);
    end
    send_op(4'd2);
    chk("stall_done_after_2nd", int'(done), 1);
    @(posedge clk); #1;

    // Reset after two of four transfers, with an operand presented at the reset edge.
    do_start(3'd4, 1'b0);
    send_op(4'd1);
    send_op(4'd2);
    chk("pre_reset_result", int'(result), 3);
    rst = 1'b1; op_valid = 1'b1; op_data = 4'd5;
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0;
    chk("midrst_result", int'(result), 0);
    chk("midrst_carry", int'(carry_out), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_op_ready", int'(op_ready), 0);
    chk("midrst_done", int'(done), 0);
    @(posedge clk); #1;
    chk("midrst_done_later", int'(done), 0);
    push_exp(4'b1001, 1'b0, 1'b0);
    do_start(3'd1, 1'b0);
    send_op(4'd9);
    chk("post_rst_done", int'(done), 1);
    @(posedge clk); #1;

    // start pulses during ACCUM and DONE must be ignored.
    push_exp(4'd7, 1'b0, 1'b0);
    do_start(3'd2, 1'b0);
    send_op(4'd3);
    start = 1'b1; count = 3'd0;
    send_op(4'd4);
    chk("ignore_done_pulse", int'(done), 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignore_no_restart", int'(done), 0);
    chk("ignore_idle_busy", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("pending_expectations", exp_q.size(), 0);
    chk("done_pulse_count", done_cnt, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
